// File: rtl/rv32i_lsu.sv
// rv32i_lsu: load/store unit between the RV32I execute stage and the
// byte-banked data memory. Aligned accesses go out as a single memory cycle;
// misaligned ones are either split into byte beats or trapped, depending on
// MISALIGNED_TRAP. Load data is assembled and sign/zero-extended before a
// single-cycle response pulse.
module rv32i_lsu #(
  parameter int unsigned MISALIGNED_TRAP = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_wr,
  output logic [1:0]  m_sz,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_mis;
  logic [1:0]  r_beat;
  logic [31:0] r_asm;
  logic [31:0] r_maddr;
  logic        r_err;
  logic [31:0] r_rdata;

  logic        w_accept;
  logic        w_legal;
  logic        w_mis;
  logic        w_reject;
  logic        w_last_beat;
  logic [31:0] w_beat_addr;
  logic [7:0]  w_beat_byte;
  logic [31:0] w_asm_nxt;
  logic [31:0] w_ext;

  // Request decode: legality and natural-alignment check on the incoming request
  always_comb begin
    w_accept = req_valid & (r_state == S_IDLE);
    if (req_we) begin
      w_legal = (req_funct3 == 3'd0) | (req_funct3 == 3'd1) | (req_funct3 == 3'd2);
    end else begin
      w_legal = (req_funct3 == 3'd0) | (req_funct3 == 3'd1) | (req_funct3 == 3'd2) |
                (req_funct3 == 3'd4) | (req_funct3 == 3'd5);
    end
    w_mis = ((req_funct3[1:0] == 2'd1) & req_addr[0]) |
            ((req_funct3[1:0] == 2'd2) & (req_addr[1:0] != 2'b00));
    w_reject = ~w_legal | (w_mis & (MISALIGNED_TRAP != 0));
  end

  // Beat sequencing, load assembly and response data extension
  always_comb begin
    if (r_mis) begin
      w_last_beat = (r_f3[1:0] == 2'd2) ? (r_beat == 2'd3) : (r_beat == 2'd1);
    end else begin
      w_last_beat = 1'b1;
    end
    w_beat_addr = r_addr + {30'd0, r_beat};
    w_beat_byte = 8'(r_wdata >> {r_beat, 3'b000});

    w_asm_nxt = r_asm;
    if (r_mis) begin
      case (r_beat)
        2'd0:    w_asm_nxt[7:0]   = m_rdata[7:0];
        2'd1:    w_asm_nxt[15:8]  = m_rdata[7:0];
        2'd2:    w_asm_nxt[23:16] = m_rdata[7:0];
        default: w_asm_nxt[31:24] = m_rdata[7:0];
      endcase
    end else begin
      case (r_f3[1:0])
        2'd0:    w_asm_nxt = {24'd0, m_rdata[7:0]};
        2'd1:    w_asm_nxt = {16'd0, m_rdata[15:0]};
        default: w_asm_nxt = m_rdata;
      endcase
    end

    case (r_f3)
      3'd0:    w_ext = {{24{w_asm_nxt[7]}}, w_asm_nxt[7:0]};
      3'd1:    w_ext = {{16{w_asm_nxt[15]}}, w_asm_nxt[15:0]};
      3'd4:    w_ext = {24'd0, w_asm_nxt[7:0]};
      3'd5:    w_ext = {16'd0, w_asm_nxt[15:0]};
      default: w_ext = w_asm_nxt;
    endcase
  end

  // Next-state logic and port outputs
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    m_addr      = r_maddr;
    m_sz        = 2'd2;
    m_wdata     = '0;
    m_wr        = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          w_state_nxt = w_reject ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        m_addr  = w_beat_addr;
        m_sz    = r_mis ? 2'd0 : r_f3[1:0];
        m_wdata = r_mis ? {24'd0, w_beat_byte} : r_wdata;
        // Gated by rst so an abandoned beat never reaches memory
        m_wr    = r_we & ~rst;
        if (w_last_beat) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign resp_err   = r_err;
  assign resp_rdata = r_rdata;

  // State register, request latch, beat counter and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mis   <= 1'b0;
      r_beat  <= '0;
      r_asm   <= '0;
      r_maddr <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_we    <= req_we;
        r_f3    <= req_funct3;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_mis   <= w_mis & w_legal;
        r_beat  <= '0;
        r_asm   <= '0;
        if (w_reject) begin
          r_err   <= 1'b1;
          r_rdata <= '0;
        end
      end else if (r_state == S_ACCESS) begin
        r_asm   <= w_asm_nxt;
        r_maddr <= w_beat_addr;
        r_beat  <= r_beat + 2'd1;
        if (w_last_beat) begin
          r_err   <= 1'b0;
          r_rdata <= r_we ? '0 : w_ext;
        end
      end
    end
  end

endmodule
